// File: rtl/vga_raster_scanner.sv
// Raster scanner: walks the H_RES x V_RES coordinate space into a pixel source,
// realigns the returned colour with its coordinate through a delay line, and
// re-emits each pixel as a framebuffer plot write.
module vga_raster_scanner #(
    parameter int unsigned H_RES   = 320,
    parameter int unsigned V_RES   = 240,
    parameter int unsigned X_W     = 9,
    parameter int unsigned Y_W     = 8,
    parameter int unsigned COL_W   = 3,
    parameter int unsigned PIX_LAT = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Enable,
    output logic [X_W-1:0]   VGAx,
    output logic [Y_W-1:0]   VGAy,
    input  logic [COL_W-1:0] VGAcol,
    output logic [X_W-1:0]   PlotX,
    output logic [Y_W-1:0]   PlotY,
    output logic [COL_W-1:0] PlotCol,
    output logic             Plot,
    output logic             Busy,
    output logic             FrameDone,
    output logic [7:0]       FrameCount
);

    localparam logic [X_W-1:0] XLast     = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] YLast     = Y_W'(V_RES - 1);
    // Drain must cover the pixel-source latency plus the plot output register.
    localparam logic [2:0]     DrainLast = 3'(PIX_LAT);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain
    } state_e;

    state_e           state_q;
    logic [X_W-1:0]   scan_x_q;
    logic [Y_W-1:0]   scan_y_q;
    logic             busy_q;
    logic [2:0]       drain_cnt_q;

    // Stage 0 of the delay line is the live scan coordinate; stages 1..PIX_LAT are registered.
    logic             stage0_valid;
    logic             pipe_valid_q [1:PIX_LAT];
    logic [X_W-1:0]   pipe_x_q     [1:PIX_LAT];
    logic [Y_W-1:0]   pipe_y_q     [1:PIX_LAT];

    logic             tap_valid;
    logic [X_W-1:0]   tap_x;
    logic [Y_W-1:0]   tap_y;
    logic             tap_last;

    logic             plot_q;
    logic [X_W-1:0]   plot_x_q;
    logic [Y_W-1:0]   plot_y_q;
    logic [COL_W-1:0] plot_col_q;
    logic             frame_done_q;
    logic [7:0]       frame_count_q;

    // Scan FSM: raster counters, drain timer and Busy, all registered.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= StIdle;
            scan_x_q    <= '0;
            scan_y_q    <= '0;
            busy_q      <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Enable) begin
                        state_q  <= StScan;
                        scan_x_q <= '0;
                        scan_y_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                StScan: begin
                    if (scan_x_q == XLast) begin
                        if (scan_y_q == YLast) begin
                            // Enable is only consulted at the frame boundary.
                            if (Enable) begin
                                scan_x_q <= '0;
                                scan_y_q <= '0;
                            end else begin
                                state_q     <= StDrain;
                                drain_cnt_q <= '0;
                            end
                        end else begin
                            scan_x_q <= '0;
                            scan_y_q <= scan_y_q + 1'b1;
                        end
                    end else begin
                        scan_x_q <= scan_x_q + 1'b1;
                    end
                end
                StDrain: begin
                    // Enable is ignored here; IDLE picks it up on the following cycle.
                    if (drain_cnt_q == DrainLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Only coordinates issued while scanning enter the delay line as valid.
    always_comb begin
        stage0_valid = (state_q == StScan);
    end

    // Delay line aligning each coordinate with the colour the source returns for it.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int unsigned k = 1; k <= PIX_LAT; k++) begin
                pipe_valid_q[k] <= 1'b0;
                pipe_x_q[k]     <= '0;
                pipe_y_q[k]     <= '0;
            end
        end else begin
            pipe_valid_q[1] <= stage0_valid;
            pipe_x_q[1]     <= scan_x_q;
            pipe_y_q[1]     <= scan_y_q;
            for (int unsigned k = 2; k <= PIX_LAT; k++) begin
                pipe_valid_q[k] <= pipe_valid_q[k-1];
                pipe_x_q[k]     <= pipe_x_q[k-1];
                pipe_y_q[k]     <= pipe_y_q[k-1];
            end
        end
    end

    // Tap decode: the coordinate whose colour is on VGAcol this cycle.
    always_comb begin
        tap_valid = pipe_valid_q[PIX_LAT];
        tap_x     = pipe_x_q[PIX_LAT];
        tap_y     = pipe_y_q[PIX_LAT];
        tap_last  = (tap_x == XLast) && (tap_y == YLast);
    end

    // Plot output register and frame accounting; plot fields hold while idle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            plot_q        <= 1'b0;
            plot_x_q      <= '0;
            plot_y_q      <= '0;
            plot_col_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            plot_q       <= tap_valid;
            frame_done_q <= tap_valid && tap_last;
            if (tap_valid) begin
                plot_x_q   <= tap_x;
                plot_y_q   <= tap_y;
                plot_col_q <= VGAcol;
                if (tap_last) begin
                    frame_count_q <= frame_count_q + 8'd1;
                end
            end
        end
    end

    assign VGAx       = scan_x_q;
    assign VGAy       = scan_y_q;
    assign Busy       = busy_q;
    assign Plot       = plot_q;
    assign PlotX      = plot_x_q;
    assign PlotY      = plot_y_q;
    assign PlotCol    = plot_col_q;
    assign FrameDone  = frame_done_q;
    assign FrameCount = frame_count_q;

endmodule

// File: tb/tb_vga_raster_scanner.sv
// Directed bench for vga_raster_scanner: a reduced 16x6 raster for the
// sequencing cases plus one full 320x240 instance scanning a single frame.
module tb_vga_raster_scanner;

    localparam int H   = 16;
    localparam int V   = 6;
    localparam int N   = H * V;
    localparam int LAT = 2;
    localparam int FULL_PIX = 320 * 240;

    logic       Clock;
    logic       Resetn;
    logic       Enable;
    logic [8:0] VGAx;
    logic [7:0] VGAy;
    logic [2:0] VGAcol;
    logic [8:0] PlotX;
    logic [7:0] PlotY;
    logic [2:0] PlotCol;
    logic       Plot;
    logic       Busy;
    logic       FrameDone;
    logic [7:0] FrameCount;

    logic       Resetn_full;
    logic       Enable_full;
    logic [8:0] VGAx_full;
    logic [7:0] VGAy_full;
    logic [2:0] VGAcol_full;
    logic [8:0] PlotX_full;
    logic [7:0] PlotY_full;
    logic [2:0] PlotCol_full;
    logic       Plot_full;
    logic       Busy_full;
    logic       FrameDone_full;
    logic [7:0] FrameCount_full;

    int vectors     = 0;
    int miscompares = 0;

    vga_raster_scanner #(
        .H_RES(H),
        .V_RES(V)
    ) u_dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Enable    (Enable),
        .VGAx      (VGAx),
        .VGAy      (VGAy),
        .VGAcol    (VGAcol),
        .PlotX     (PlotX),
        .PlotY     (PlotY),
        .PlotCol   (PlotCol),
        .Plot      (Plot),
        .Busy      (Busy),
        .FrameDone (FrameDone),
        .FrameCount(FrameCount)
    );

    vga_raster_scanner u_dut_full (
        .Clock     (Clock),
        .Resetn    (Resetn_full),
        .Enable    (Enable_full),
        .VGAx      (VGAx_full),
        .VGAy      (VGAy_full),
        .VGAcol    (VGAcol_full),
        .PlotX     (PlotX_full),
        .PlotY     (PlotY_full),
        .PlotCol   (PlotCol_full),
        .Plot      (Plot_full),
        .Busy      (Busy_full),
        .FrameDone (FrameDone_full),
        .FrameCount(FrameCount_full)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [2:0] pix(input logic [8:0] x, input logic [7:0] y);
        return {x[0], y[0], x[1]};
    endfunction

    // Pixel sources: two register stages then a colour lookup.
    logic [8:0] sx1, sx2, fx1, fx2;
    logic [7:0] sy1, sy2, fy1, fy2;
    always @(posedge Clock) begin
        sx1 <= VGAx;      sy1 <= VGAy;      sx2 <= sx1; sy2 <= sy1;
        fx1 <= VGAx_full; fy1 <= VGAy_full; fx2 <= fx1; fy2 <= fy1;
    end
    assign VGAcol      = pix(sx2, sy2);
    assign VGAcol_full = pix(fx2, fy2);

    // Scoreboard for the full-size frame: plots must arrive in raster order with model colour.
    int full_plots = 0;
    int full_bad   = 0;
    int full_done  = 0;
    int bx         = 0;
    int by         = 0;
    always @(negedge Clock) begin
        if (Plot_full === 1'b1) begin
            if (PlotX_full !== 9'(bx) || PlotY_full !== 8'(by) ||
                PlotCol_full !== pix(9'(bx), 8'(by)))
                full_bad <= full_bad + 1;
            full_plots <= full_plots + 1;
            if (bx == 319) begin
                bx <= 0;
                by <= (by == 239) ? 0 : by + 1;
            end else begin
                bx <= bx + 1;
            end
        end
        if (FrameDone_full === 1'b1) full_done <= full_done + 1;
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_vgax"},    32'(VGAx),       0);
        chk({pfx, "_vgay"},    32'(VGAy),       0);
        chk({pfx, "_plotx"},   32'(PlotX),      0);
        chk({pfx, "_ploty"},   32'(PlotY),      0);
        chk({pfx, "_plotcol"}, 32'(PlotCol),    0);
        chk({pfx, "_plot"},    32'(Plot),       0);
        chk({pfx, "_busy"},    32'(Busy),       0);
        chk({pfx, "_fdone"},   32'(FrameDone),  0);
        chk({pfx, "_fcount"},  32'(FrameCount), 0);
    endtask

    // c: cycles since first (0,0); c_end: last scan cycle; base: FrameCount at start.
    task automatic run_check(input int c, input int c_end, input int base);
        int   i, p, q;
        logic exp_plot;
        i = (c <= c_end) ? c : c_end;
        chk("vgax", 32'(VGAx), 32'(i % H));
        chk("vgay", 32'(VGAy), 32'((i / H) % V));
        chk("busy", 32'(Busy), 32'(c <= c_end + LAT + 1));
        p        = c - (LAT + 1);
        exp_plot = (p >= 0) && (p <= c_end);
        chk("plot", 32'(Plot), 32'(exp_plot));
        chk("framedone", 32'(FrameDone), 32'(exp_plot && (p % N == N - 1)));
        q = (p > c_end) ? c_end : p;
        chk("framecount", 32'(FrameCount),
            (p < 0) ? 32'(base % 256) : 32'((base + (q + 1) / N) % 256));
        if (p >= 0) begin
            chk("plotx", 32'(PlotX), 32'(q % H));
            chk("ploty", 32'(PlotY), 32'((q / H) % V));
            chk("plotcol", 32'(PlotCol), 32'(pix(9'(q % H), 8'((q / H) % V))));
        end
    endtask

    initial begin
        Resetn      = 1'b0;
        Enable      = 1'b0;
        Resetn_full = 1'b0;
        Enable_full = 1'b0;
        repeat (3) tick;
        chk_zero("reset");

        Resetn      = 1'b1;
        Resetn_full = 1'b1;
        Enable_full = 1'b1;
        tick;
        tick;
        chk("idle_busy", 32'(Busy), 0);

        // Run A: three frames; Enable drops at (10,4) of the third, which still completes.
        Enable = 1'b1;
        tick;
        Enable_full = 1'b0;
        for (int c = 0; c <= 291; c++) begin
            run_check(c, 287, 0);
            if (c == 266) Enable = 1'b0;
            if (c < 291) tick;
        end

        // Run B: Enable low for exactly the end-of-frame edge, high again during drain.
        Enable = 1'b1;
        tick;
        for (int c = 0; c <= 99; c++) begin
            run_check(c, 95, 3);
            if (c == 95) Enable = 1'b0;
            if (c == 96) Enable = 1'b1;
            if (c < 99) tick;
        end
        tick;

        // Run C: asynchronous reset lands mid-scan at (10,3).
        for (int c = 0; c <= 58; c++) begin
            run_check(c, 1 << 30, 4);
            if (c < 58) tick;
        end
        #2 Resetn = 1'b0;
        #1 chk_zero("async");
        tick;
        chk("held_busy", 32'(Busy), 0);
        Resetn = 1'b1;
        tick;

        // Run D: 256 continuous frames, FrameCount wraps to 0 on the last FrameDone.
        for (int c = 0; c <= 256 * N + LAT + 1; c++) begin
            run_check(c, 1 << 30, 0);
            tick;
        end

        // Full-size instance: one frame then drain.
        for (int k = 0; k < 80000 && Busy_full !== 1'b0; k++) tick;
        tick;
        chk("full_idle",   32'(Busy_full),       0);
        chk("full_plots",  32'(full_plots),      32'(FULL_PIX));
        chk("full_order",  32'(full_bad),        0);
        chk("full_fdone",  32'(full_done),       1);
        chk("full_fcount", 32'(FrameCount_full), 1);
        chk("full_plot",   32'(Plot_full),       0);
        chk("full_lastx",  32'(PlotX_full),      319);
        chk("full_lasty",  32'(PlotY_full),      239);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
